// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter with terminal-count detection, used as a timeout and
// interval source. A loaded value is counted down to zero under `enable`;
// reaching the terminal edge pulses `expired` for one cycle, after which the
// timer either stops (one-shot) or reloads the last loaded value and repeats
// (periodic).
//
// Ports:
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   load        in   1      capture load_value into counter and reload register
//   load_value  in   WIDTH  start / reload count
//   enable      in   1      decrement qualifier (only meaningful while counting)
//   periodic    in   1      0 = one-shot, 1 = auto-reload at the terminal edge
//   value       out  WIDTH  current count (registered)
//   busy        out  1      high while counting (registered)
//   expired     out  1      one-cycle terminal-count pulse (registered)
// ---------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             periodic,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] value_q,   value_d;
  logic [WIDTH-1:0] reload_q,  reload_d;
  logic             busy_q,    busy_d;
  logic             expired_q, expired_d;

  // The terminal edge is the enabled edge taken while the count is 1. The
  // compare uses <= so that a count of 0 in COUNT (unreachable in normal
  // operation) still terminates instead of wrapping to all-ones.
  logic             at_terminal_s;

  // Next-state / next-output computation for the counter FSM.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    reload_d      = reload_q;
    expired_d     = 1'b0;
    at_terminal_s = (value_q <= VAL_ONE);

    if (load) begin
      // Load has priority over everything except reset, including a
      // coincident terminal edge, so no expiry is reported in that case.
      value_d  = load_value;
      reload_d = load_value;
      if (load_value != VAL_ZERO) begin
        state_d = ST_COUNT;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (enable) begin
            if (at_terminal_s) begin
              expired_d = 1'b1;
              if (periodic) begin
                // Periodic mode jumps straight back to the reload value; the
                // count never shows 0 here.
                value_d = reload_q;
                state_d = ST_COUNT;
              end else begin
                value_d = VAL_ZERO;
                state_d = ST_IDLE;
              end
            end else begin
              value_d = value_q - VAL_ONE;
            end
          end else begin
            value_d = value_q;
          end
        end
        ST_IDLE: begin
          // Holding: enable is ignored and the count never underflows.
          value_d = value_q;
        end
        default: begin
          state_d = ST_IDLE;
          value_d = VAL_ZERO;
        end
      endcase
    end

    busy_d = (state_d == ST_COUNT);
  end

  // State, count, reload register and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      value_q   <= VAL_ZERO;
      reload_q  <= VAL_ZERO;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign value   = value_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed bench for countdown_timer (WIDTH=4). Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, i.e. away
// from the active edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  logic       clock;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       periodic;
  logic [3:0] value;
  logic       busy;
  logic       expired;

  int total;
  int bad;

  countdown_timer #(.WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .periodic   (periodic),
    .value      (value),
    .busy       (busy),
    .expired    (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] v, input logic b, input logic e);
    chk({tag, ".value"},   {28'd0, value},   {28'd0, v});
    chk({tag, ".busy"},    {31'd0, busy},    {31'd0, b});
    chk({tag, ".expired"}, {31'd0, expired}, {31'd0, e});
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] per_val [9];
  logic       per_exp [9];
  logic       gate_en [4];
  logic [3:0] gate_val[4];
  logic       gate_exp[4];

  initial begin
    total = 0;
    bad   = 0;
    per_val  = '{4'h2, 4'h1, 4'h3, 4'h2, 4'h1, 4'h3, 4'h2, 4'h1, 4'h3};
    per_exp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    gate_en  = '{1'b1, 1'b0, 1'b0, 1'b1};
    gate_val = '{4'h1, 4'h1, 4'h1, 4'h0};
    gate_exp = '{1'b0, 1'b0, 1'b0, 1'b1};

    reset      = 1'b0;
    load       = 1'b0;
    load_value = 4'h0;
    enable     = 1'b0;
    periodic   = 1'b0;

    // Reset state.
    #3;
    chk_all("reset_init", 4'h0, 1'b0, 1'b0);
    step();
    reset = 1'b1;

    // Count down from 7 to 5, then assert reset between edges.
    load = 1'b1; load_value = 4'h7; enable = 1'b1;
    step();
    chk_all("pre_rst_load", 4'h7, 1'b1, 1'b0);
    load = 1'b0;
    step();
    step();
    chk_all("pre_rst_cnt", 4'h5, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    // enable=1, no load: nothing moves, no expiry.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("post_rst_idle", 4'h0, 1'b0, 1'b0);
    end

    // One-shot from 3.
    load = 1'b1; load_value = 4'h3; enable = 1'b1; periodic = 1'b0;
    step();
    chk_all("os_load", 4'h3, 1'b1, 1'b0);
    load = 1'b0;
    step();
    chk_all("os_2", 4'h2, 1'b1, 1'b0);
    step();
    chk_all("os_1", 4'h1, 1'b1, 1'b0);
    step();
    chk_all("os_0", 4'h0, 1'b0, 1'b1);
    step();
    chk_all("os_after", 4'h0, 1'b0, 1'b0);
    step();
    chk_all("os_nowrap", 4'h0, 1'b0, 1'b0);

    // Periodic from 3 over 9 enabled edges.
    load = 1'b1; load_value = 4'h3; periodic = 1'b1;
    step();
    chk_all("per_load", 4'h3, 1'b1, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_all("per_seq", per_val[i], 1'b1, per_exp[i]);
    end

    // Switch to one-shot mid-count: next terminal edge stops.
    periodic = 1'b0;
    step();
    chk_all("per_to_os_2", 4'h2, 1'b1, 1'b0);
    step();
    step();
    chk_all("per_to_os_stop", 4'h0, 1'b0, 1'b1);

    // Enable gating from 2 with pattern 1,0,0,1.
    load = 1'b1; load_value = 4'h2;
    step();
    chk_all("gate_load", 4'h2, 1'b1, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable = gate_en[i];
      step();
      chk_all("gate_seq", gate_val[i], gate_val[i] != 4'h0, gate_exp[i]);
    end

    // Load collides with the terminal edge.
    enable = 1'b1;
    load = 1'b1; load_value = 4'h1;
    step();
    chk_all("col_load1", 4'h1, 1'b1, 1'b0);
    load_value = 4'hA;
    step();
    chk_all("col_loadA", 4'hA, 1'b1, 1'b0);
    load_value = 4'h0;
    step();
    chk_all("col_load0", 4'h0, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_all("col_idle", 4'h0, 1'b0, 1'b0);

    // Full range one-shot from F.
    load = 1'b1; load_value = 4'hF;
    step();
    chk_all("full_load", 4'hF, 1'b1, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk_all("full_seq", 4'(15 - k), k != 15, k == 15);
    end
    step();
    chk_all("full_after", 4'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
